// File: rtl/present_block_fetch.sv
// ----------------------------------------------------------------------------
// present_block_fetch
// Streams 64-bit PRESENT plaintext blocks out of a 32-bit on-chip memory.
// Each block is two consecutive words: the first word read becomes the upper
// half of the block, the second word the lower half. Blocks are handed to the
// cipher core over a valid/ready stream, one block per 4 cycles at best.
//
// Optional build macro: PRESENT_FETCH_BSWAP_EN
//   When defined, every captured word is byte-reversed before it is stored
//   (0x11223344 -> 0x44332211). Timing is identical in both builds.
// ----------------------------------------------------------------------------
module present_block_fetch #(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  blk_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic [63:0]       blk_data,
    output logic              blk_valid,
    input  logic              blk_ready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_HI,
        RD_LO,
        CAP_LO,
        HOLD,
        FIN
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [ADDR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]    r_remaining;
    logic [63:0]         r_blk_data;

    logic [ADDR_W-1:0]   w_ptr_inc;
    logic [31:0]         w_word;
    logic                w_load;
    logic                w_cap_hi;
    logic                w_cap_lo;

    // Word formatting applied on capture; the only place the build option acts.
    function automatic logic [31:0] fmt_word(input logic [31:0] word);
`ifdef PRESENT_FETCH_BSWAP_EN
        return {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
        return word;
`endif
    endfunction

    // Second word of the pair; the add is ADDR_W wide so it wraps naturally.
    assign w_ptr_inc = r_ptr + ADDR_W'(1);
    assign w_word    = fmt_word(mem_readdata);

    // Write port of the memory is never used by this block.
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_writedata  = 32'h0;
    assign mem_clken      = 1'b1;

    assign blk_data = r_blk_data;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples pre-edge values.
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        // NOTE: every output gets a default here so no path infers a latch.
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_cap_hi       = 1'b0;
        w_cap_lo       = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        blk_valid      = 1'b0;
        mem_chipselect = 1'b0;
        mem_address    = r_ptr;

        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (blk_count != '0) begin
                        w_load       = 1'b1;
                        w_next_state = RD_HI;
                    end else begin
                        w_next_state = FIN;
                    end
                end
            end
            RD_HI: begin
                mem_chipselect = 1'b1;
                w_next_state   = RD_LO;
            end
            RD_LO: begin
                // Upper word arrives now while the lower word is requested.
                mem_chipselect = 1'b1;
                mem_address    = w_ptr_inc;
                w_cap_hi       = 1'b1;
                w_next_state   = CAP_LO;
            end
            CAP_LO: begin
                w_cap_lo     = 1'b1;
                w_next_state = HOLD;
            end
            HOLD: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    w_next_state = (r_remaining != '0) ? RD_HI : FIN;
                end
            end
            FIN: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Address pointer, block counter and captured block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_blk_data  <= '0;
        end else begin
            if (w_load) begin
                r_ptr       <= base_addr;
                r_remaining <= blk_count;
            end
            if (w_cap_hi) begin
                r_blk_data[63:32] <= w_word;
            end
            if (w_cap_lo) begin
                r_blk_data[31:0] <= w_word;
                r_ptr            <= r_ptr + ADDR_W'(2);
                r_remaining      <= r_remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_present_block_fetch.sv
// ----------------------------------------------------------------------------
// tb_present_block_fetch
// Directed bench for present_block_fetch with a zero-wait-state memory model.
// Expected blocks follow the build: define PRESENT_FETCH_BSWAP_EN for both
// files together to exercise the byte-reversed variant.
// ----------------------------------------------------------------------------
module tb_present_block_fetch;

    localparam int ADDR_W = 15;
    localparam int CNT_W  = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  blk_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata = 32'h0;
    logic [63:0]       blk_data;
    logic              blk_valid;
    logic              blk_ready;

    int checks = 0;
    int errors = 0;

    present_block_fetch #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .blk_count      (blk_count),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .blk_data       (blk_data),
        .blk_valid      (blk_valid),
        .blk_ready      (blk_ready)
    );

    always #5 clk = ~clk;

    // Memory model: data valid one cycle after a selected address.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem[mem_address];
    end

    // Mid-cycle monitor: read addresses, handshakes and done pulses.
    int                cyc = 0;
    int                done_cnt = 0;
    int                start_cyc = 0;
    logic [ADDR_W-1:0] addr_q[$];
    logic [63:0]       blk_q[$];
    int                hs_q[$];
    always @(negedge clk) begin
        if (mem_chipselect) addr_q.push_back(mem_address);
        if (blk_valid && blk_ready) begin
            blk_q.push_back(blk_data);
            hs_q.push_back(cyc);
        end
        if (done) done_cnt++;
        cyc++;
    end

    // Expected block from two memory words, following the build option.
    function automatic logic [63:0] exp_blk(input logic [31:0] hi, input logic [31:0] lo);
`ifdef PRESENT_FETCH_BSWAP_EN
        return {hi[7:0], hi[15:8], hi[23:16], hi[31:24],
                lo[7:0], lo[15:8], lo[23:16], lo[31:24]};
`else
        return {hi, lo};
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        addr_q.delete();
        blk_q.delete();
        hs_q.delete();
        done_cnt = 0;
    endtask

    // Pulse start for one cycle; on return the DUT is in its first run cycle.
    task automatic do_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
        base_addr = base;
        blk_count = cnt;
        start     = 1'b1;
        start_cyc = cyc;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", blk_valid); end
        checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b exp=0", mem_chipselect); end
        checks++; if (mem_address !== 15'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
        checks++; if (blk_data !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", blk_data); end
        checks++;
        if (mem_write !== 1'b0 || mem_byteenable !== 4'hF || mem_writedata !== 32'h0 || mem_clken !== 1'b1) begin
            errors++;
            $display("FAIL tie_offs got we=%b be=%h wd=%h ce=%b exp we=0 be=f wd=0 ce=1",
                     mem_write, mem_byteenable, mem_writedata, mem_clken);
        end
    endtask

    task automatic test_single();
        clear_mon();
        blk_ready = 1'b1;
        do_start(15'h10, 14'd1);
        checks++; if (mem_chipselect !== 1'b1 || mem_address !== 15'h10) begin errors++; $display("FAIL single_rd_hi got cs=%b a=%h exp cs=1 a=10", mem_chipselect, mem_address); end
        tick(1);
        checks++; if (mem_chipselect !== 1'b1 || mem_address !== 15'h11) begin errors++; $display("FAIL single_rd_lo got cs=%b a=%h exp cs=1 a=11", mem_chipselect, mem_address); end
        tick(1);
        checks++; if (mem_chipselect !== 1'b0 || blk_valid !== 1'b0) begin errors++; $display("FAIL single_cap got cs=%b v=%b exp cs=0 v=0", mem_chipselect, blk_valid); end
        tick(1);
        checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", blk_valid); end
        checks++; if (blk_data !== exp_blk(32'h01234567, 32'h89ABCDEF)) begin errors++; $display("FAIL single_data got=%h exp=%h", blk_data, exp_blk(32'h01234567, 32'h89ABCDEF)); end
`ifdef PRESENT_FETCH_BSWAP_EN
        checks++; if (blk_data !== 64'h67452301EFCDAB89) begin errors++; $display("FAIL bswap_data got=%h exp=67452301efcdab89", blk_data); end
`else
        checks++; if (blk_data !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL plain_data got=%h exp=0123456789abcdef", blk_data); end
`endif
        tick(1);
        checks++; if (done !== 1'b1 || busy !== 1'b1 || blk_valid !== 1'b0) begin errors++; $display("FAIL single_fin got d=%b b=%b v=%b exp d=1 b=1 v=0", done, busy, blk_valid); end
        tick(1);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got d=%b b=%b exp d=0 b=0", done, busy); end
        checks++; if (hs_q.size() != 1 || hs_q[0] != start_cyc + 4) begin errors++; $display("FAIL single_latency got n=%0d exp n=1 at cycle %0d", hs_q.size(), start_cyc + 4); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [63:0] exp_q[3];
        exp_q[0] = exp_blk(32'h01234567, 32'h89ABCDEF);
        exp_q[1] = exp_blk(32'hDEADBEEF, 32'hCAFEF00D);
        exp_q[2] = exp_blk(32'h00112233, 32'h44556677);
        clear_mon();
        blk_ready = 1'b1;
        do_start(15'h10, 14'd3);
        wait_idle(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got busy=%b exp idle", busy); end
        checks++; if (addr_q.size() != 6) begin errors++; $display("FAIL b2b_nreads got=%0d exp=6", addr_q.size()); end
        for (int i = 0; i < 6 && i < addr_q.size(); i++) begin
            checks++; if (addr_q[i] !== 15'(16 + i)) begin errors++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, addr_q[i], 15'(16 + i)); end
        end
        checks++; if (blk_q.size() != 3) begin errors++; $display("FAIL b2b_nblk got=%0d exp=3", blk_q.size()); end
        for (int i = 0; i < 3 && i < blk_q.size(); i++) begin
            checks++; if (blk_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_blk[%0d] got=%h exp=%h", i, blk_q[i], exp_q[i]); end
            checks++; if (hs_q[i] != start_cyc + 4 * (i + 1)) begin errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, hs_q[i], start_cyc + 4 * (i + 1)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_stall();
        bit ok;
        logic [63:0] e0;
        e0 = exp_blk(32'h01234567, 32'h89ABCDEF);
        clear_mon();
        blk_ready = 1'b0;
        do_start(15'h10, 14'd2);
        tick(3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (blk_valid !== 1'b1 || blk_data !== e0 || mem_chipselect !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d] got v=%b d=%h cs=%b exp v=1 d=%h cs=0", i, blk_valid, blk_data, mem_chipselect, e0);
            end
            tick(1);
        end
        checks++; if (addr_q.size() != 2) begin errors++; $display("FAIL stall_noread got=%0d exp=2", addr_q.size()); end
        blk_ready = 1'b1;
        tick(1);
        checks++; if (mem_chipselect !== 1'b1 || mem_address !== 15'h12) begin errors++; $display("FAIL stall_resume got cs=%b a=%h exp cs=1 a=12", mem_chipselect, mem_address); end
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got busy=%b exp idle", busy); end
        checks++; if (blk_q.size() != 2 || blk_q[1] !== exp_blk(32'hDEADBEEF, 32'hCAFEF00D)) begin errors++; $display("FAIL stall_blk2 got n=%0d exp n=2 with second block %h", blk_q.size(), exp_blk(32'hDEADBEEF, 32'hCAFEF00D)); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_mon();
        blk_ready = 1'b1;
        do_start(15'h7FFF, 14'd1);
        checks++; if (mem_address !== 15'h7FFF) begin errors++; $display("FAIL wrap_hi got=%h exp=7fff", mem_address); end
        tick(1);
        checks++; if (mem_address !== 15'h0000) begin errors++; $display("FAIL wrap_lo got=%h exp=0000", mem_address); end
        wait_idle(20, ok);
        checks++; if (!ok || blk_q.size() != 1 || blk_q[0] !== exp_blk(32'hA1B2C3D4, 32'h5E6F7081)) begin errors++; $display("FAIL wrap_blk got n=%0d exp one block %h", blk_q.size(), exp_blk(32'hA1B2C3D4, 32'h5E6F7081)); end
    endtask

    task automatic test_zero_count();
        clear_mon();
        do_start(15'h20, 14'd0);
        checks++; if (busy !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL zero_fin got b=%b d=%b exp b=1 d=1", busy, done); end
        tick(1);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero_idle got b=%b d=%b exp b=0 d=0", busy, done); end
        checks++; if (addr_q.size() != 0 || done_cnt != 1) begin errors++; $display("FAIL zero_access got reads=%0d dones=%0d exp 0 and 1", addr_q.size(), done_cnt); end
    endtask

    task automatic test_reset_mid_run();
        clear_mon();
        blk_ready = 1'b0;
        do_start(15'h10, 14'd1);
        tick(1);
        base_addr = 15'h40;
        blk_count = 14'd5;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        tick(1);
        checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL mid_hold got v=%b exp=1", blk_valid); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (blk_valid !== 1'b0 || busy !== 1'b0 || mem_chipselect !== 1'b0 || blk_data !== 64'h0 || mem_address !== 15'h0) begin
            errors++;
            $display("FAIL mid_reset got v=%b b=%b cs=%b d=%h a=%h exp all zero", blk_valid, busy, mem_chipselect, blk_data, mem_address);
        end
        tick(6);
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL mid_nodone got=%0d exp=0", done_cnt); end
        checks++; if (addr_q.size() != 2 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_ignored got reads=%0d b=%b exp 2 and 0", addr_q.size(), busy); end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA5000000 ^ i;
        mem[15'h10]   = 32'h01234567;
        mem[15'h11]   = 32'h89ABCDEF;
        mem[15'h12]   = 32'hDEADBEEF;
        mem[15'h13]   = 32'hCAFEF00D;
        mem[15'h14]   = 32'h00112233;
        mem[15'h15]   = 32'h44556677;
        mem[15'h7FFF] = 32'hA1B2C3D4;
        mem[15'h0000] = 32'h5E6F7081;

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        blk_count = '0;
        blk_ready = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_zero_count();
        test_reset_mid_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
